// File: rtl/fetch_unit.sv
// fetch_unit -- instruction-fetch front end feeding the decode stage.
//
// Owns the fetch PC. Issues one word request at a time to instruction memory.
// Returned words are buffered with their PC in a small prefetch queue. The
// queue head is presented to decode. A redirect flushes the queue and
// discards any response still in flight.
//
// Optional feature: define FETCH_STATS_EN to add the stat_fetched and
// stat_flushes counters. With it undefined those ports and counters are
// absent.
//
// Handshake semantics (both interfaces):
//   imem side : a request transfers in a cycle where imem_req && imem_gnt.
//               imem_addr stays stable while imem_req=1 and imem_gnt=0.
//               imem_rvalid returns data in order, at least one cycle after
//               the grant.
//   decode    : the head transfers in a cycle where if_valid && if_ready.
//               if_valid does not depend on if_ready.
//
// Ports:
//   clk, rst          rising-edge clock; synchronous active-high reset
//   imem_req/addr     fetch request and its byte address (word aligned)
//   imem_gnt          request accepted this cycle
//   imem_rvalid/rdata response strobe and instruction word
//   redirect_valid/pc restart fetch at redirect_pc (bits [1:0] ignored)
//   if_valid/ready    decode handshake for the queue head
//   if_instr/if_pc    head instruction and its byte address (0 when empty)
//   stat_fetched      (FETCH_STATS_EN) count of if_valid && if_ready cycles
//   stat_flushes      (FETCH_STATS_EN) count of redirect_valid cycles
//   dbg_state         fetch FSM state (0=RUN, 1=WAIT, 2=WAIT_DROP)

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
`ifdef FETCH_STATS_EN
  output logic [31:0] stat_fetched,
  output logic [31:0] stat_flushes,
`endif
  output logic [1:0]  dbg_state
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  // RUN: nothing outstanding. WAIT: one request outstanding, keep its data.
  // WAIT_DROP: one request outstanding, but a redirect made it stale.
  typedef enum logic [1:0] {
    RUN       = 2'd0,
    WAIT      = 2'd1,
    WAIT_DROP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     fpc_q;
  logic [31:0]     req_pc_q;     // PC of the outstanding request
  logic [31:0]     instr_mem [DEPTH];
  logic [31:0]     pc_mem    [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   used;
  logic            pending, space, fire, push, pop, not_empty;

  assign dbg_state = state_q;
  assign not_empty = (count_q != '0);
  assign pending   = (state_q != RUN);

  // One slot stays reserved for the word already in flight. Without the
  // reservation, a full queue could receive a response it has no room for.
  assign used  = count_q + CW'(pending);
  assign space = (used < CW'(DEPTH));

  // A new request is issued from RUN, or in the very cycle the outstanding
  // response returns. That keeps issue at one per cycle without ever having
  // two requests outstanding. A redirect blocks issue for its cycle, so the
  // first redirected request goes out with the updated fpc.
  assign imem_req  = !rst && !redirect_valid && space &&
                     ((state_q == RUN) || ((state_q == WAIT) && imem_rvalid));
  assign imem_addr = fpc_q;
  assign fire      = imem_req && imem_gnt;

  // A redirect suppresses both queue push and pop; the queue is then cleared.
  assign push = !redirect_valid && (state_q == WAIT) && imem_rvalid;
  assign pop  = !redirect_valid && if_valid && if_ready;

  assign if_valid = !rst && not_empty;
  assign if_instr = not_empty ? instr_mem[rd_ptr_q] : 32'h0;
  assign if_pc    = not_empty ? pc_mem[rd_ptr_q]    : 32'h0;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (fire) state_d = WAIT;
      end
      WAIT: begin
        if (redirect_valid) begin
          // A response arriving together with the redirect is simply
          // dropped. That closes the transaction, so no drop state is needed.
          state_d = imem_rvalid ? RUN : WAIT_DROP;
        end else if (imem_rvalid) begin
          state_d = fire ? WAIT : RUN;
        end
      end
      WAIT_DROP: begin
        if (imem_rvalid) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // A response still in flight at reset returns while in RUN and is ignored.
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Fetch PC and the PC tag of the outstanding request
  always_ff @(posedge clk) begin
    if (rst) begin
      fpc_q    <= RESET_PC;
      req_pc_q <= RESET_PC;
    end else if (redirect_valid) begin
      fpc_q <= redirect_pc & 32'hFFFF_FFFC;
    end else if (fire) begin
      fpc_q    <= fpc_q + 32'd4;
      req_pc_q <= fpc_q;
    end
  end

  // Prefetch queue storage: a plain circular buffer, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= imem_rdata;
      pc_mem[wr_ptr_q]    <= req_pc_q;
    end
  end

  // Pointers and occupancy. Pop requires a non-empty queue, and the push
  // requires a reserved slot, so count stays within 0..DEPTH.
  always_ff @(posedge clk) begin
    if (rst || redirect_valid) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef FETCH_STATS_EN
  // Event counters; both wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_fetched <= 32'd0;
      stat_flushes <= 32'd0;
    end else begin
      if (if_valid && if_ready) stat_fetched <= stat_fetched + 32'd1;
      if (redirect_valid)       stat_flushes <= stat_flushes + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit -- randomized bench for fetch_unit.
//
// The driver plays instruction memory and decode. The memory holds at most
// one outstanding request with a random response latency, and returns
// rdata = addr ^ 32'hA5A5_0000. For each kept response, the driver pushes the
// word decode should see into exp_q. Redirects and resets empty exp_q.
// The monitor runs on the falling edge. It pops exp_q on each accepted
// handshake and compares the pc/instr. It also checks if_valid, imem_req and
// imem_addr against the reference model state.
// RESET_PC is placed near the top of the address space so that fpc wraps
// early in the run.

module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'hFFFF_FFF0;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] KEY      = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [1:0]  dbg_state;
`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched;
  logic [31:0] stat_flushes;
  logic [31:0] m_fetched = 32'd0, m_flushes = 32'd0;
  logic [31:0] m_fetched_prev = 32'd0, m_flushes_prev = 32'd0;
`endif

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .if_valid(if_valid),
    .if_ready(if_ready),
    .if_instr(if_instr),
    .if_pc(if_pc),
`ifdef FETCH_STATS_EN
    .stat_fetched(stat_fetched),
    .stat_flushes(stat_flushes),
`endif
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [63:0] exp_q[$];          // {pc, instr} in decode order
  int          checks = 0;
  int          passed = 0;
  bit          started = 1'b0;
  int          vis_len = 0;       // entries decode may see this cycle
  bit          req_exp = 1'b0;    // model says a request is due this cycle
  logic [31:0] m_fpc = RESET_PC;  // model fetch address

  // Memory model: at most one request in flight
  bit          have_out = 1'b0;
  bit          out_live = 1'b0;
  int          out_lat  = 0;
  logic [31:0] out_addr = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (started) begin
      if (rst) begin
        check("rst_if_valid", {31'b0, if_valid}, 32'd0);
        check("rst_imem_req", {31'b0, imem_req}, 32'd0);
      end else begin
        check("if_valid", {31'b0, if_valid}, {31'b0, vis_len != 0});
        check("imem_req", {31'b0, imem_req}, {31'b0, req_exp});
        if (imem_req && req_exp) check("imem_addr", imem_addr, m_fpc);
        if (!if_valid) begin
          check("empty_if_pc", if_pc, 32'h0);
          check("empty_if_instr", if_instr, 32'h0);
        end else if (if_ready && !redirect_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL underflow: got pc %h with no word expected at %0t", if_pc, $time);
          end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            check("if_pc", if_pc, e[63:32]);
            check("if_instr", if_instr, e[31:0]);
          end
        end
      end
`ifdef FETCH_STATS_EN
      check("stat_fetched", stat_fetched, m_fetched_prev);
      check("stat_flushes", stat_flushes, m_flushes_prev);
`endif
    end
  end

  // ---------------- driver ----------------
  initial begin
    int gnt_pct, lat_max, ready_pct, redir_pct;
    bit rst_now, redir, had_out, deliver;
    logic [31:0] tgt;
    started = 1'b1;
    for (int ph = 0; ph < 7; ph++) begin
      case (ph)
        0: begin gnt_pct = 100; lat_max = 0; ready_pct = 100; redir_pct = 0;  end
        1: begin gnt_pct = 100; lat_max = 1; ready_pct = 0;   redir_pct = 0;  end
        2: begin gnt_pct = 70;  lat_max = 2; ready_pct = 70;  redir_pct = 4;  end
        3: begin gnt_pct = 25;  lat_max = 3; ready_pct = 80;  redir_pct = 2;  end
        4: begin gnt_pct = 60;  lat_max = 2; ready_pct = 60;  redir_pct = 3;  end
        5: begin gnt_pct = 80;  lat_max = 1; ready_pct = 50;  redir_pct = 20; end
        default: begin gnt_pct = 100; lat_max = 0; ready_pct = 100; redir_pct = 0; end
      endcase
      for (int c = 0; c < 400; c++) begin
        @(posedge clk); #1;
        // Phase 1 holds decode off long enough to fill the queue.
        if (ph == 1 && c == 60) ready_pct = 100;
        rst_now = (ph == 0 && c < 2) || (ph == 4 && c >= 200 && c < 203);
        redir   = !rst_now && ($urandom_range(0, 99) < redir_pct);
        had_out = have_out;
        deliver = have_out && (out_lat == 0);
        vis_len = exp_q.size();
        req_exp = !rst_now && !redir && ((vis_len + (had_out ? 1 : 0)) < DEPTH) &&
                  (!had_out || (deliver && out_live));
`ifdef FETCH_STATS_EN
        m_fetched_prev = m_fetched;
        m_flushes_prev = m_flushes;
        if (vis_len != 0 && !rst_now && (if_ready || 1'b0)) begin end
`endif
        // memory response
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (rst_now) begin
          have_out = 1'b0;
        end else if (deliver) begin
          imem_rvalid = 1'b1;
          imem_rdata  = out_addr ^ KEY;
          if (out_live && !redir) exp_q.push_back({out_addr, out_addr ^ KEY});
          have_out = 1'b0;
        end else if (have_out) begin
          out_lat--;
          if (redir) out_live = 1'b0;
        end else if ($urandom_range(0, 99) < 4) begin
          imem_rvalid = 1'b1;     // stray strobe with nothing outstanding
        end
        if (rst_now || redir) exp_q.delete();
        if (rst_now) begin
          m_fpc = RESET_PC;
        end else if (redir) begin
          tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                            : 32'($urandom);
          redirect_pc = tgt;
          m_fpc = tgt & 32'hFFFF_FFFC;
        end
        rst            = rst_now;
        redirect_valid = redir;
        imem_gnt       = ($urandom_range(0, 99) < gnt_pct);
        if_ready       = ($urandom_range(0, 99) < ready_pct);
`ifdef FETCH_STATS_EN
        if (rst_now) begin
          m_fetched = 32'd0;
          m_flushes = 32'd0;
        end else begin
          if (vis_len != 0 && if_ready) m_fetched = m_fetched + 32'd1;
          if (redir) m_flushes = m_flushes + 32'd1;
        end
`endif
        // Grant is sampled after the monitor has checked the request address.
        @(negedge clk); #1;
        if (!rst_now && imem_req && imem_gnt) begin
          have_out = 1'b1;
          out_live = 1'b1;
          out_addr = m_fpc;
          out_lat  = $urandom_range(0, lat_max);
          m_fpc    = m_fpc + 32'd4;
        end
      end
    end
    @(posedge clk); #1;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
